plate_frame_tx: RTL

- Transmit side of the camera-to-recognition image interface.
- Accepts full 3072-bit plate frames from up to five lane cameras and arbitrates round-robin among them.
- Streams each frame to the recognition core as three 1024-bit slices, tagged with a one-hot lane select and a slice index (1, 2, 3).
- Sits between the lane camera front-ends and the plate-recognition/violation-logging core.

---
 rtl/plate_frame_tx_if.sv | 26 ++
 rtl/plate_frame_tx.sv | 123 ++++++++++++
 2 files changed

// File: rtl/plate_frame_tx_if.sv
// Camera-side frame request bus and recognition-side slice stream of plate_frame_tx.
// The transmitter takes the master modport and the lane cameras plus consumer take slave.
interface plate_frame_tx_if #(
  parameter int LANES   = 5,
  parameter int SLICE_W = 1024,
  parameter int NSLICE  = 3
);
  logic [LANES-1:0]                frame_valid;
  logic [LANES*NSLICE*SLICE_W-1:0] frame_data;
  logic [LANES-1:0]                frame_ready;
  logic [SLICE_W-1:0]              img_data;
  logic [1:0]                      slice_idx;
  logic [LANES-1:0]                signal;
  logic                            img_valid;
  logic                            img_ready;

  modport master (
    input  frame_valid, frame_data, img_ready,
    output frame_ready, img_data, slice_idx, signal, img_valid
  );

  modport slave (
    output frame_valid, frame_data, img_ready,
    input  frame_ready, img_data, slice_idx, signal, img_valid
  );
endinterface

// File: rtl/plate_frame_tx.sv
// Round-robin arbiter over lane cameras; buffers one full plate frame and streams it
// to the recognition core as NSLICE slices, most-significant slice first.
module plate_frame_tx #(
  parameter int LANES   = 5,
  parameter int SLICE_W = 1024,
  parameter int NSLICE  = 3,
  parameter int GAP     = 1
) (
  input  logic             clk,
  input  logic             reset,
  plate_frame_tx_if.master bus,
  output logic             busy,
  output logic [15:0]      frames_sent
);
  localparam int FRAME_W = NSLICE * SLICE_W;
  localparam int LW      = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int GW      = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t             state, state_nxt;
  logic [LW-1:0]      ptr;
  logic [LW-1:0]      grant_idx;
  logic [LW-1:0]      cand;
  logic               grant_found;
  logic [LANES-1:0]   lane_oh;
  logic [LANES-1:0]   frame_ready_q;
  logic [1:0]         slice_cnt;
  logic [GW-1:0]      gap_cnt;
  logic [FRAME_W-1:0] frame_buf;
  logic               xfer;
  logic               last_slice;

  assign xfer        = (state == S_SEND) && bus.img_ready;
  assign last_slice  = (slice_cnt == 2'(NSLICE));
  assign bus.frame_ready = frame_ready_q;

  // First requesting lane strictly after the pointer, wrapping modulo LANES.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= LANES; i++) begin
      cand = LW'((int'(ptr) + i) % LANES);
      if (!grant_found && bus.frame_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // NOTE: sequential state uses <= only; every comb block assigns defaults first so no latch is inferred.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (grant_found) state_nxt = S_SEND;
      S_SEND: if (xfer && last_slice) state_nxt = (GAP > 0) ? S_GAP : S_IDLE;
      S_GAP:  if (gap_cnt == GW'(GAP - 1)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr           <= LW'(LANES - 1);
      lane_oh       <= '0;
      slice_cnt     <= '0;
      gap_cnt       <= '0;
      frame_ready_q <= '0;
      frames_sent   <= '0;
    end else begin
      frame_ready_q <= '0;
      case (state)
        S_IDLE: if (grant_found) begin
          ptr           <= grant_idx;
          lane_oh       <= LANES'(1) << grant_idx;
          frame_ready_q <= LANES'(1) << grant_idx;
          slice_cnt     <= 2'd1;
        end
        S_SEND: if (xfer) begin
          if (last_slice) begin
            slice_cnt   <= '0;
            lane_oh     <= '0;
            gap_cnt     <= '0;
            frames_sent <= frames_sent + 16'd1;
          end else begin
            slice_cnt <= slice_cnt + 2'd1;
          end
        end
        S_GAP:   gap_cnt <= gap_cnt + GW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: the frame buffer is pure datapath and is not reset; img_data is masked outside SEND.
  // The current slice always sits in the top SLICE_W bits; each accepted slice shifts the next one up.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && grant_found)
      frame_buf <= bus.frame_data[int'(grant_idx)*FRAME_W +: FRAME_W];
    else if (xfer)
      frame_buf <= frame_buf << SLICE_W;
  end

  always_comb begin
    bus.img_valid = 1'b0;
    bus.slice_idx = '0;
    bus.signal    = '0;
    bus.img_data  = '0;
    busy          = (state != S_IDLE);
    if (state == S_SEND) begin
      bus.img_valid = 1'b1;
      bus.slice_idx = slice_cnt;
      bus.signal    = lane_oh;
      bus.img_data  = frame_buf[FRAME_W-1 -: SLICE_W];
    end
  end
endmodule
